// File: rtl/exc_commit_ctrl_pkg.sv
// exc_pkg: shared definitions for the MEM-stage exception commit controller.
//   - EXC_* exception codes as written to CP0 (ExcCode values)
//   - default exception vector
//   - controller state encoding
//   - CP0 Status/Cause bit positions used for interrupt qualification
//   - exc_rec_t: one complete exception record (what gets committed to CP0)
package exc_pkg;

  localparam logic [4:0] EXC_INT     = 5'h01;
  localparam logic [4:0] EXC_ADEL    = 5'h04;
  localparam logic [4:0] EXC_ADES    = 5'h05;
  localparam logic [4:0] EXC_SYSCALL = 5'h08;
  localparam logic [4:0] EXC_BREAK   = 5'h09;
  localparam logic [4:0] EXC_RI      = 5'h0A;
  localparam logic [4:0] EXC_OV      = 5'h0C;
  localparam logic [4:0] EXC_TRAP    = 5'h0D;
  localparam logic [4:0] EXC_ERET    = 5'h0E;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int IM_LO      = 8;
  localparam int IM_HI      = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] pc;
    logic        delayslot;
    logic [31:0] bad_addr;
    logic [31:0] redirect_pc;
  } exc_rec_t;

  // Interrupt is pending when globally enabled, not already in exception
  // level, and at least one unmasked interrupt line is asserted.
  function automatic logic int_pending(input logic [31:0] status,
                                       input logic [31:0] cause);
    return status[STATUS_IE] & ~status[STATUS_EXL] &
           (|(cause[IM_HI:IM_LO] & status[IM_HI:IM_LO]));
  endfunction

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// exc_commit_ctrl_if: bundle of MEM-stage, CP0 and redirect signals between
// the pipeline (master) and the exception commit controller (slave).
//   master: drives stall, MEM-stage instruction info, CP0 register values;
//           receives the CP0 exception record, flush and fetch redirect.
//   slave : the controller side (mirror image).
interface exc_commit_ctrl_if;

  logic        stall_i;
  logic        m_valid_i;
  logic [31:0] m_pc_i;
  logic        m_in_delayslot_i;
  logic        m_adel_if_i;
  logic        m_ri_i;
  logic        m_ov_i;
  logic        m_trap_i;
  logic        m_syscall_i;
  logic        m_break_i;
  logic        m_adel_ld_i;
  logic        m_ades_i;
  logic        m_eret_i;
  logic [31:0] m_mem_addr_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;

  logic [31:0] excepttype_o;
  logic [31:0] exc_pc_o;
  logic        exc_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  modport master (
    output stall_i, m_valid_i, m_pc_i, m_in_delayslot_i,
           m_adel_if_i, m_ri_i, m_ov_i, m_trap_i, m_syscall_i, m_break_i,
           m_adel_ld_i, m_ades_i, m_eret_i, m_mem_addr_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  excepttype_o, exc_pc_o, exc_delayslot_o, bad_addr_o,
           flush_o, redirect_valid_o, redirect_pc_o, busy_o
  );

  modport slave (
    input  stall_i, m_valid_i, m_pc_i, m_in_delayslot_i,
           m_adel_if_i, m_ri_i, m_ov_i, m_trap_i, m_syscall_i, m_break_i,
           m_adel_ld_i, m_ades_i, m_eret_i, m_mem_addr_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i,
    output excepttype_o, exc_pc_o, exc_delayslot_o, bad_addr_o,
           flush_o, redirect_valid_o, redirect_pc_o, busy_o
  );

endinterface

// File: rtl/exc_commit_ctrl_prio_enc.sv
// exc_prio_enc: combinational exception priority encoder.
//   in : valid, int_pend, per-instruction exception flags, pc, mem_addr
//   out: exc_valid (some cause present), code (top-priority ExcCode),
//        bad_addr (BadVAddr for address errors, else 0)
// All flags, including the interrupt, are ignored when valid=0.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic        valid,
  input  logic        int_pend,
  input  logic        adel_if,
  input  logic        ri,
  input  logic        ov,
  input  logic        trap,
  input  logic        syscall,
  input  logic        brk,
  input  logic        adel_ld,
  input  logic        ades,
  input  logic        eret,
  input  logic [31:0] pc,
  input  logic [31:0] mem_addr,
  output logic        exc_valid,
  output logic [4:0]  code,
  output logic [31:0] bad_addr
);

  always_comb begin
    exc_valid = 1'b1;
    code      = '0;
    bad_addr  = '0;
    if (!valid) begin
      exc_valid = 1'b0;
    end else if (int_pend) begin
      code = EXC_INT;
    end else if (adel_if) begin
      code     = EXC_ADEL;
      bad_addr = pc;
    end else if (ri) begin
      code = EXC_RI;
    end else if (ov) begin
      code = EXC_OV;
    end else if (trap) begin
      code = EXC_TRAP;
    end else if (syscall) begin
      code = EXC_SYSCALL;
    end else if (brk) begin
      code = EXC_BREAK;
    end else if (adel_ld) begin
      code     = EXC_ADEL;
      bad_addr = mem_addr;
    end else if (ades) begin
      code     = EXC_ADES;
      bad_addr = mem_addr;
    end else if (eret) begin
      // eret is lowest priority, so any other flag on the same
      // instruction wins and eret is simply dropped.
      code = EXC_ERET;
    end else begin
      exc_valid = 1'b0;
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: MEM-stage exception/interrupt commit controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : exc_commit_ctrl_if.slave -- stall, MEM instruction flags,
//              CP0 Status/Cause/EPC in; CP0 exception record, flush and
//              fetch redirect out; busy_o high outside IDLE.
// CP0 ignores writes during a stall, so an exception detected while stalled
// is parked in a hold register and committed on the first unstalled cycle.
// After every commit, BLANK_CYCLES unstalled cycles of MEM inputs are ignored
// so the flushed instruction cannot raise a second exception.
module exc_commit_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int          BLANK_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  exc_commit_ctrl_if.slave   bus
);

  localparam logic [1:0] BLANK_LAST = 2'(BLANK_CYCLES - 1);

  state_e     state_q, state_d;
  exc_rec_t   hold_q, hold_d;
  logic [1:0] cnt_q, cnt_d;

  logic       enc_valid;
  logic [4:0] enc_code;
  logic [31:0] enc_bad_addr;
  logic       int_pend;

  exc_rec_t   live_rec;
  exc_rec_t   commit_rec;
  logic       do_commit;

  assign int_pend = int_pending(bus.cp0_status_i, bus.cp0_cause_i);

  exc_prio_enc u_prio_enc (
    .valid     (bus.m_valid_i),
    .int_pend  (int_pend),
    .adel_if   (bus.m_adel_if_i),
    .ri        (bus.m_ri_i),
    .ov        (bus.m_ov_i),
    .trap      (bus.m_trap_i),
    .syscall   (bus.m_syscall_i),
    .brk       (bus.m_break_i),
    .adel_ld   (bus.m_adel_ld_i),
    .ades      (bus.m_ades_i),
    .eret      (bus.m_eret_i),
    .pc        (bus.m_pc_i),
    .mem_addr  (bus.m_mem_addr_i),
    .exc_valid (enc_valid),
    .code      (enc_code),
    .bad_addr  (enc_bad_addr)
  );

  always_comb begin
    live_rec.code        = enc_code;
    live_rec.pc          = bus.m_pc_i;
    live_rec.delayslot   = bus.m_in_delayslot_i;
    live_rec.bad_addr    = enc_bad_addr;
    // The redirect target is resolved here so that a held eret keeps the
    // EPC value seen at detection time.
    live_rec.redirect_pc = (enc_code == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    do_commit  = 1'b0;
    commit_rec = live_rec;

    unique case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          if (!bus.stall_i) begin
            do_commit = 1'b1;
            state_d   = ST_BLANK;
            cnt_d     = '0;
          end else begin
            hold_d  = live_rec;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        commit_rec = hold_q;
        if (!bus.stall_i) begin
          do_commit = 1'b1;
          state_d   = ST_BLANK;
          cnt_d     = '0;
        end
      end
      ST_BLANK: begin
        if (!bus.stall_i) begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while rst is asserted so a live cause on the
  // reset cycle never reaches CP0.
  always_comb begin
    bus.excepttype_o     = '0;
    bus.exc_pc_o         = '0;
    bus.exc_delayslot_o  = 1'b0;
    bus.bad_addr_o       = '0;
    bus.flush_o          = 1'b0;
    bus.redirect_valid_o = 1'b0;
    bus.redirect_pc_o    = '0;
    bus.busy_o           = (state_q != ST_IDLE) && !rst;
    if (do_commit && !rst) begin
      bus.excepttype_o     = {27'd0, commit_rec.code};
      bus.exc_pc_o         = commit_rec.pc;
      bus.exc_delayslot_o  = commit_rec.delayslot;
      bus.bad_addr_o       = commit_rec.bad_addr;
      bus.flush_o          = 1'b1;
      bus.redirect_valid_o = 1'b1;
      bus.redirect_pc_o    = commit_rec.redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb_exc_commit_ctrl: directed, table-driven bench for exc_commit_ctrl plus
// hand-written sequences for stall hold, BLANK, EPC capture and reset.
module tb_exc_commit_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  exc_commit_ctrl_if bus ();

  exc_commit_ctrl #(
    .EXC_VECTOR   (32'hBFC0_0380),
    .BLANK_CYCLES (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  // flag bits: 8 adel_if, 7 ri, 6 ov, 5 trap, 4 syscall, 3 break,
  //            2 adel_ld, 1 ades, 0 eret
  typedef struct {
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] addr;
    logic        valid;
    logic        ds;
    logic [8:0]  fl;
    logic [31:0] e_code;
    logic [31:0] e_pc;
    logic        e_ds;
    logic [31:0] e_bad;
    logic [31:0] e_redir;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.stall_i          = 1'b0;
    bus.m_valid_i        = 1'b0;
    bus.m_pc_i           = '0;
    bus.m_in_delayslot_i = 1'b0;
    bus.m_adel_if_i      = 1'b0;
    bus.m_ri_i           = 1'b0;
    bus.m_ov_i           = 1'b0;
    bus.m_trap_i         = 1'b0;
    bus.m_syscall_i      = 1'b0;
    bus.m_break_i        = 1'b0;
    bus.m_adel_ld_i      = 1'b0;
    bus.m_ades_i         = 1'b0;
    bus.m_eret_i         = 1'b0;
    bus.m_mem_addr_i     = '0;
    bus.cp0_status_i     = '0;
    bus.cp0_cause_i      = '0;
    bus.cp0_epc_i        = '0;
  endtask

  task automatic set_flags(input logic [8:0] fl);
    bus.m_adel_if_i = fl[8];
    bus.m_ri_i      = fl[7];
    bus.m_ov_i      = fl[6];
    bus.m_trap_i    = fl[5];
    bus.m_syscall_i = fl[4];
    bus.m_break_i   = fl[3];
    bus.m_adel_ld_i = fl[2];
    bus.m_ades_i    = fl[1];
    bus.m_eret_i    = fl[0];
  endtask

  // Every output quiet; busy compared against the given value.
  task automatic chk_quiet(input string tag, input logic busy_exp);
    chk({tag, ".excepttype"}, bus.excepttype_o, 32'h0);
    chk({tag, ".flush"}, {31'd0, bus.flush_o}, 32'h0);
    chk({tag, ".redir_v"}, {31'd0, bus.redirect_valid_o}, 32'h0);
    chk({tag, ".busy"}, {31'd0, bus.busy_o}, {31'd0, busy_exp});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_inputs();

    //            status        cause         epc           pc            addr          v     ds    fl      code   e_pc          e_ds  e_bad         e_redir
    vt[0]  = '{32'h0000_0401, 32'h0000_0400, 32'h0,        32'hBFC0_1000, 32'h0,        1'b1, 1'b0, 9'h000, 32'h1, 32'hBFC0_1000, 1'b0, 32'h0,        VEC};
    vt[1]  = '{32'h0000_0403, 32'h0000_0400, 32'h0,        32'hBFC0_1000, 32'h0,        1'b1, 1'b0, 9'h000, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0};
    vt[2]  = '{32'h0,        32'h0,        32'h0,        32'hBFC0_0104, 32'h0,        1'b1, 1'b1, 9'h0D0, 32'hA, 32'hBFC0_0104, 1'b1, 32'h0,        VEC};
    vt[3]  = '{32'h0,        32'h0,        32'hBFC0_0700, 32'hBFC0_0200, 32'h0,        1'b1, 1'b0, 9'h001, 32'hE, 32'hBFC0_0200, 1'b0, 32'h0,        32'hBFC0_0700};
    vt[4]  = '{32'h0,        32'h0,        32'h0,        32'hBFC0_0002, 32'h0,        1'b1, 1'b0, 9'h180, 32'h4, 32'hBFC0_0002, 1'b0, 32'hBFC0_0002, VEC};
    vt[5]  = '{32'h0,        32'h0,        32'h0,        32'hBFC0_0300, 32'h8000_0001, 1'b1, 1'b0, 9'h004, 32'h4, 32'hBFC0_0300, 1'b0, 32'h8000_0001, VEC};
    vt[6]  = '{32'h0,        32'h0,        32'hBFC0_0700, 32'hBFC0_0400, 32'h0,        1'b1, 1'b0, 9'h009, 32'h9, 32'hBFC0_0400, 1'b0, 32'h0,        VEC};
    vt[7]  = '{32'h0,        32'h0,        32'h0,        32'hBFC0_0440, 32'h0,        1'b0, 1'b0, 9'h040, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0};
    vt[8]  = '{32'h0,        32'h0,        32'h0,        32'hBFC0_0500, 32'h0,        1'b1, 1'b0, 9'h030, 32'hD, 32'hBFC0_0500, 1'b0, 32'h0,        VEC};
    vt[9]  = '{32'h0000_0400, 32'h0000_0400, 32'h0,        32'hBFC0_0540, 32'h0,        1'b1, 1'b0, 9'h000, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0};
    vt[10] = '{32'h0000_0401, 32'h0000_0400, 32'h0,        32'hBFC0_0600, 32'h0,        1'b1, 1'b1, 9'h040, 32'h1, 32'hBFC0_0600, 1'b1, 32'h0,        VEC};
    vt[11] = '{32'h0,        32'h0,        32'h0,        32'hBFC0_0604, 32'h0,        1'b1, 1'b0, 9'h040, 32'hC, 32'hBFC0_0604, 1'b0, 32'h0,        VEC};
    vt[12] = '{32'h0000_0801, 32'h0000_0400, 32'h0,        32'hBFC0_0640, 32'h0,        1'b1, 1'b0, 9'h000, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0};

    // Reset: outputs stay zero even with a live cause present.
    rst = 1'b1;
    @(negedge clk);
    bus.m_valid_i = 1'b1;
    bus.m_ov_i    = 1'b1;
    #1;
    chk_quiet("reset_live", 1'b0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk_quiet("reset", 1'b0);
    rst = 1'b0;
    $display("reset: checked outputs");

    // Table-driven single-instruction commits from IDLE.
    for (int i = 0; i < 13; i++) begin
      logic commit_exp;
      commit_exp = (vt[i].e_code != 32'h0);
      @(negedge clk);
      bus.cp0_status_i     = vt[i].status;
      bus.cp0_cause_i      = vt[i].cause;
      bus.cp0_epc_i        = vt[i].epc;
      bus.m_pc_i           = vt[i].pc;
      bus.m_mem_addr_i     = vt[i].addr;
      bus.m_valid_i        = vt[i].valid;
      bus.m_in_delayslot_i = vt[i].ds;
      set_flags(vt[i].fl);
      #1;
      chk($sformatf("v%0d.excepttype", i), bus.excepttype_o, vt[i].e_code);
      chk($sformatf("v%0d.exc_pc", i), bus.exc_pc_o, vt[i].e_pc);
      chk($sformatf("v%0d.delayslot", i), {31'd0, bus.exc_delayslot_o}, {31'd0, vt[i].e_ds});
      chk($sformatf("v%0d.bad_addr", i), bus.bad_addr_o, vt[i].e_bad);
      chk($sformatf("v%0d.flush", i), {31'd0, bus.flush_o}, {31'd0, commit_exp});
      chk($sformatf("v%0d.redir_v", i), {31'd0, bus.redirect_valid_o}, {31'd0, commit_exp});
      chk($sformatf("v%0d.redir_pc", i), bus.redirect_pc_o, vt[i].e_redir);
      $display("vec %0d: excepttype=%h exc_pc=%h bad=%h redir=%h", i,
               bus.excepttype_o, bus.exc_pc_o, bus.bad_addr_o, bus.redirect_pc_o);
      // Same inputs held one more cycle: BLANK must ignore them.
      @(negedge clk);
      #1;
      chk_quiet($sformatf("v%0d.next", i), commit_exp);
      @(negedge clk);
      clear_inputs();
      #1;
      chk_quiet($sformatf("v%0d.idle", i), 1'b0);
    end

    // Held misaligned store: three stalled cycles, then exactly one commit.
    @(negedge clk);
    bus.stall_i      = 1'b1;
    bus.m_valid_i    = 1'b1;
    bus.m_pc_i       = 32'hBFC0_0800;
    bus.m_ades_i     = 1'b1;
    bus.m_mem_addr_i = 32'h8000_0006;
    #1;
    chk_quiet("ades.st0", 1'b0);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      // Inputs change during the hold; they must be ignored.
      bus.m_ades_i = 1'b0;
      bus.m_ov_i   = 1'b1;
      #1;
      chk_quiet($sformatf("ades.st%0d", c), 1'b1);
    end
    @(negedge clk);
    bus.stall_i = 1'b0;
    #1;
    chk("ades.code", bus.excepttype_o, 32'h5);
    chk("ades.bad", bus.bad_addr_o, 32'h8000_0006);
    chk("ades.pc", bus.exc_pc_o, 32'hBFC0_0800);
    chk("ades.flush", {31'd0, bus.flush_o}, 32'h1);
    chk("ades.redir", bus.redirect_pc_o, VEC);
    $display("held ades: excepttype=%h bad=%h", bus.excepttype_o, bus.bad_addr_o);
    @(negedge clk);
    clear_inputs();
    #1;
    chk_quiet("ades.after", 1'b1);
    @(negedge clk);
    #1;
    chk_quiet("ades.idle", 1'b0);

    // Held eret: EPC changes during the stall must not move the target.
    @(negedge clk);
    bus.stall_i   = 1'b1;
    bus.m_valid_i = 1'b1;
    bus.m_pc_i    = 32'hBFC0_0900;
    bus.m_eret_i  = 1'b1;
    bus.cp0_epc_i = 32'hBFC0_0700;
    @(negedge clk);
    bus.cp0_epc_i = 32'hBFC0_0A00;
    bus.m_valid_i = 1'b0;
    #1;
    chk_quiet("eret_hold.st", 1'b1);
    @(negedge clk);
    bus.stall_i = 1'b0;
    #1;
    chk("eret_hold.code", bus.excepttype_o, 32'hE);
    chk("eret_hold.redir", bus.redirect_pc_o, 32'hBFC0_0700);
    $display("held eret: excepttype=%h redir=%h", bus.excepttype_o, bus.redirect_pc_o);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);

    // Stalled BLANK cycles do not count toward the blank window.
    @(negedge clk);
    bus.m_valid_i = 1'b1;
    bus.m_pc_i    = 32'hBFC0_0B00;
    bus.m_ov_i    = 1'b1;
    #1;
    chk("blank.first", bus.excepttype_o, 32'hC);
    @(negedge clk);
    bus.stall_i = 1'b1;
    #1;
    chk_quiet("blank.st1", 1'b1);
    @(negedge clk);
    #1;
    chk_quiet("blank.st2", 1'b1);
    @(negedge clk);
    bus.stall_i = 1'b0;
    #1;
    chk_quiet("blank.count", 1'b1);
    @(negedge clk);
    #1;
    chk("blank.retake", bus.excepttype_o, 32'hC);
    $display("blank window: retake excepttype=%h", bus.excepttype_o);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);

    // Reset while holding a break: the held cause is discarded.
    @(negedge clk);
    bus.stall_i   = 1'b1;
    bus.m_valid_i = 1'b1;
    bus.m_pc_i    = 32'hBFC0_0C00;
    bus.m_break_i = 1'b1;
    @(negedge clk);
    #1;
    chk_quiet("rsthold.hold", 1'b1);
    rst = 1'b1;
    bus.m_valid_i = 1'b0;
    bus.m_break_i = 1'b0;
    @(negedge clk);
    #1;
    chk_quiet("rsthold.rst", 1'b0);
    rst = 1'b0;
    bus.stall_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk_quiet($sformatf("rsthold.after%0d", c), 1'b0);
    end
    $display("reset during hold: checked no commit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Exception/interrupt commit controller at the MEM stage of the MIPS pipeline. It sits between the pipeline and the CP0 register file.
- Each cycle it:
  - merges the per-instruction exception flags with the pending-interrupt condition,
  - picks the single highest-priority cause,
  - drives the CP0 exception-record inputs,
  - flushes the pipeline and redirects fetch to the exception vector or to EPC (eret).
- While the pipeline is stalled, CP0 ignores all updates. The controller therefore holds a detected exception until the stall drops, then commits it exactly once.

Parameters:
- EXC_VECTOR, 32'hBFC00380, fetch redirect target for every exception except eret.
- BLANK_CYCLES, 1, cycles after a commit during which MEM-stage inputs are ignored (range 1..3).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall_i  in  1  global pipeline stall (cache stall); CP0 frozen while 1
- m_valid_i  in  1  MEM stage holds a real instruction
- m_pc_i  in  32  MEM-stage instruction PC
- m_in_delayslot_i  in  1  MEM instruction is in a branch delay slot
- m_adel_if_i  in  1  misaligned fetch
- m_ri_i  in  1  reserved instruction
- m_ov_i  in  1  arithmetic overflow
- m_trap_i  in  1  trap condition true
- m_syscall_i  in  1  syscall
- m_break_i  in  1  break
- m_adel_ld_i  in  1  misaligned load
- m_ades_i  in  1  misaligned store
- m_eret_i  in  1  eret
- m_mem_addr_i  in  32  load/store effective address
- cp0_status_i  in  32  CP0 Status
- cp0_cause_i  in  32  CP0 Cause
- cp0_epc_i  in  32  CP0 EPC
- excepttype_o  out  32  exception code to CP0; 0 = none
- exc_pc_o  out  32  faulting PC to CP0
- exc_delayslot_o  out  1  delay-slot flag to CP0
- bad_addr_o  out  32  BadVAddr value to CP0
- flush_o  out  1  kill IF..MEM, including the MEM-stage store
- redirect_valid_o  out  1  load redirect_pc_o into PC
- redirect_pc_o  out  32  fetch target
- busy_o  out  1  state is not IDLE

Behaviour:
- **Reset:** rst is sampled on posedge clk. State goes to IDLE, the hold register is cleared, and all outputs are 0. A reset while in HOLD discards the held exception, and no commit occurs.
- **Interrupt pending:**
  - int_pend = status[0] & ~status[1] & |(cause[15:8] & status[15:8]).
  - An interrupt is only taken when attached to a valid MEM instruction (m_valid_i=1).
- **Priority, high to low, with codes:**
  - int 0x01
  - adel_if 0x04
  - ri 0x0A
  - ov 0x0C
  - trap 0x0D
  - syscall 0x08
  - break 0x09
  - adel_ld 0x04
  - ades 0x05
  - eret 0x0E
- **Flags are ignored when m_valid_i=0.**
- **bad_addr_o:** equals m_pc_i for adel_if, m_mem_addr_i for adel_ld/ades, and 0 otherwise.
- **redirect_pc_o:** equals cp0_epc_i for eret and EXC_VECTOR for all other codes.
- **IDLE state:**
  - If a cause is detected and stall_i=0, commit in the same cycle (combinational):
    - excepttype_o/exc_pc_o/exc_delayslot_o/bad_addr_o driven from live inputs,
    - flush_o=1, redirect_valid_o=1,
    - next state BLANK.
  - If a cause is detected and stall_i=1, latch {code, pc, delayslot, bad_addr, redirect target}; all outputs stay 0; next state HOLD.
- **HOLD state:**
  - Outputs are 0 while stall_i=1, and new inputs are ignored.
  - The first cycle with stall_i=0 commits from the hold register (the same output set as an IDLE commit); next state BLANK.
  - The eret target is captured at latch time; an EPC change during the hold does not alter it.
- **BLANK state:**
  - Counts BLANK_CYCLES cycles with stall_i=0, then returns to IDLE.
  - MEM inputs are ignored throughout, so an interrupt or exception cannot be taken twice on a flushed instruction.
  - Stalled cycles do not count.
- **Single-cycle commit:** excepttype_o is nonzero for exactly one non-stalled cycle per exception. Outside a commit it is 0.
- **Combined flags:** several flags on one instruction produce only the top-priority code. eret combined with any other flag commits the other cause.
- **busy_o:** equals 1 in HOLD and BLANK.

Decomposition:
- Shared package exc_pkg:
  - EXC_* code constants 0x01..0x0E,
  - EXC_VECTOR default,
  - state enum {IDLE, HOLD, BLANK},
  - Status/Cause bit-index constants (IE=0, EXL=1, IM/IP=15:8).
- Sub-module exc_prio_enc (combinational): takes the flags, int_pend, m_pc_i and m_mem_addr_i, and produces {valid, code, bad_addr}.

Test Plan:
- **Interrupt:** status=0x00000401, cause=0x00000400, m_valid=1, pc=0xBFC01000, stall=0. Required: same cycle excepttype_o=0x1, exc_pc_o=0xBFC01000, flush_o=1, redirect_pc_o=0xBFC00380; next cycle busy_o=1 and all outputs 0.
- **Masked interrupt:** same stimulus with status=0x00000403 (EXL=1). Required: excepttype_o=0, flush_o=0.
- **Held misaligned store:** m_ades=1, m_mem_addr=0x80000006, stall=1 for 3 cycles. Required: outputs 0 during the stall. On the first cycle with stall=0: excepttype_o=0x5 and bad_addr_o=0x80000006 for exactly one cycle.
- **Priority:** ri=1 together with syscall=1 and ov=1, in delay slot, pc=0xBFC00104. Required: excepttype_o=0xA, exc_delayslot_o=1, exc_pc_o=0xBFC00104.
- **eret:** epc=0xBFC00700, m_eret=1. Required: excepttype_o=0xE, redirect_pc_o=0xBFC00700. The next cycle's flags are ignored (BLANK).
- **Reset during HOLD:** stall=1 with break=1, then rst=1. Required: all outputs 0, and no commit after stall drops.
